// File: rtl/xrange_xfifo.sv
// Two-channel FIFO between a descending [HI:LO] bus and an ascending [LO:HI] bus.
// Channel c buffers i<c>; with CROSS="TRUE" channel 0 drains to o1 and channel 1 to o0.

module xrange_xfifo_chan #(
  parameter int            W        = 5,
  parameter int            DEPTH    = 16,
  parameter int            AF_LEVEL = 10,
  parameter logic [W-1:0]  IDLE_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [W-1:0]             wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     af
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_LVL = (PW+1)'(DEPTH);
  localparam logic [PW:0]     AF_LVL   = (PW+1)'(AF_LEVEL);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level_nxt;
  logic          push;
  logic          pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. wr_ready depends only on registered level and rst, never on wr_valid.
  assign wr_ready = (level != FULL_LVL) && !rst;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready && !rst;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + (PW+1)'(1);
      2'b01:   level_nxt = level - (PW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      af       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_nxt;
      rd_valid <= (level_nxt != '0);
      af       <= (level_nxt >= AF_LVL);
    end
  end

  // Storage is not reset; an emptied level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : IDLE_VAL;

endmodule

module xrange_xfifo #(
  parameter int              HI       = 2,
  parameter int              LO       = -2,
  parameter int              DEPTH    = 16,
  parameter int              AF_LEVEL = 10,
  parameter string           CROSS    = "TRUE",
  parameter string           MAP      = "POSITIONAL",
  parameter logic [HI-LO:0]  IDLE_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i0_valid,
  output logic                    i0_ready,
  input  logic [HI:LO]            i0,
  input  logic                    i1_valid,
  output logic                    i1_ready,
  input  logic [LO:HI]            i1,
  output logic                    o0_valid,
  input  logic                    o0_ready,
  output logic [HI:LO]            o0,
  output logic                    o1_valid,
  input  logic                    o1_ready,
  output logic [LO:HI]            o1,
  output logic [$clog2(DEPTH):0]  level0,
  output logic [$clog2(DEPTH):0]  level1,
  output logic                    af0,
  output logic                    af1
);

  localparam int W        = HI - LO + 1;
  localparam bit CROSSED  = (CROSS == "TRUE");
  localparam bit BY_INDEX = (MAP == "INDEX");

  if (HI < LO) begin : g_bad_range
    $error("xrange_xfifo: HI (%0d) must not be below LO (%0d)", HI, LO);
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("xrange_xfifo: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("xrange_xfifo: AF_LEVEL (%0d) must be within 1..DEPTH", AF_LEVEL);
  end
  if (!((CROSS == "TRUE") || (CROSS == "FALSE"))) begin : g_bad_cross
    $error("xrange_xfifo: CROSS must be \"TRUE\" or \"FALSE\"");
  end
  if (!((MAP == "POSITIONAL") || (MAP == "INDEX"))) begin : g_bad_map
    $error("xrange_xfifo: MAP must be \"POSITIONAL\" or \"INDEX\"");
  end

  // Flat vectors keep MSB-first order, so a plain copy is the positional mapping;
  // index mapping across opposite orientations is a bit reversal.
  logic [W-1:0] s0, s1, r0, r1, w0, w1;
  assign s0 = i0;
  assign s1 = i1;

  for (genvar b = 0; b < W; b++) begin : g_rev
    assign r0[b] = s0[W-1-b];
    assign r1[b] = s1[W-1-b];
  end

  if (CROSSED && BY_INDEX) begin : g_map_rev
    assign w0 = r0;
    assign w1 = r1;
  end else begin : g_map_pos
    assign w0 = s0;
    assign w1 = s1;
  end

  logic [W-1:0] d0, d1;
  logic         v0, v1;
  logic         rr0, rr1;

  xrange_xfifo_chan #(
    .W(W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .IDLE_VAL(IDLE_VAL)
  ) u_ch0 (
    .clk(clk), .rst(rst),
    .wr_valid(i0_valid), .wr_ready(i0_ready), .wr_data(w0),
    .rd_valid(v0), .rd_ready(rr0), .rd_data(d0),
    .level(level0), .af(af0)
  );

  xrange_xfifo_chan #(
    .W(W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .IDLE_VAL(IDLE_VAL)
  ) u_ch1 (
    .clk(clk), .rst(rst),
    .wr_valid(i1_valid), .wr_ready(i1_ready), .wr_data(w1),
    .rd_valid(v1), .rd_ready(rr1), .rd_data(d1),
    .level(level1), .af(af1)
  );

  if (CROSSED) begin : g_cross
    assign rr0      = o1_ready;
    assign rr1      = o0_ready;
    assign o1_valid = v0;
    assign o1       = d0;
    assign o0_valid = v1;
    assign o0       = d1;
  end else begin : g_straight
    assign rr0      = o0_ready;
    assign rr1      = o1_ready;
    assign o0_valid = v0;
    assign o0       = d0;
    assign o1_valid = v1;
    assign o1       = d1;
  end

endmodule

// File: tb/tb_xrange_xfifo.sv
// Directed bench for xrange_xfifo: default crossed/positional instance, an INDEX
// instance and a narrow uncrossed 8-bit instance, checked through per-output scoreboards.

module tb_xrange_xfifo;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance (crossed, positional)
  logic        m_i0_valid, m_i0_ready, m_i1_valid, m_i1_ready;
  logic [2:-2] m_i0;
  logic [-2:2] m_i1;
  logic        m_o0_valid, m_o0_ready, m_o1_valid, m_o1_ready;
  logic [2:-2] m_o0;
  logic [-2:2] m_o1;
  logic [4:0]  m_level0, m_level1;
  logic        m_af0, m_af1;

  // index-mapped instance
  logic        x_i0_valid, x_i0_ready, x_i1_valid, x_i1_ready;
  logic [2:-2] x_i0;
  logic [-2:2] x_i1;
  logic        x_o0_valid, x_o0_ready, x_o1_valid, x_o1_ready;
  logic [2:-2] x_o0;
  logic [-2:2] x_o1;
  logic [4:0]  x_level0, x_level1;
  logic        x_af0, x_af1;

  // narrow uncrossed instance
  logic        s_i0_valid, s_i0_ready, s_i1_valid, s_i1_ready;
  logic [3:-4] s_i0;
  logic [-4:3] s_i1;
  logic        s_o0_valid, s_o0_ready, s_o1_valid, s_o1_ready;
  logic [3:-4] s_o0;
  logic [-4:3] s_o1;
  logic [2:0]  s_level0, s_level1;
  logic        s_af0, s_af1;

  logic [4:0] q_m_o0[$];
  logic [4:0] q_m_o1[$];
  logic [4:0] q_x_o0[$];
  logic [4:0] q_x_o1[$];
  logic [7:0] q_s_o0[$];
  logic [7:0] q_s_o1[$];

  xrange_xfifo dut_m (
    .clk(clk), .rst(rst),
    .i0_valid(m_i0_valid), .i0_ready(m_i0_ready), .i0(m_i0),
    .i1_valid(m_i1_valid), .i1_ready(m_i1_ready), .i1(m_i1),
    .o0_valid(m_o0_valid), .o0_ready(m_o0_ready), .o0(m_o0),
    .o1_valid(m_o1_valid), .o1_ready(m_o1_ready), .o1(m_o1),
    .level0(m_level0), .level1(m_level1), .af0(m_af0), .af1(m_af1)
  );

  xrange_xfifo #(.MAP("INDEX")) dut_x (
    .clk(clk), .rst(rst),
    .i0_valid(x_i0_valid), .i0_ready(x_i0_ready), .i0(x_i0),
    .i1_valid(x_i1_valid), .i1_ready(x_i1_ready), .i1(x_i1),
    .o0_valid(x_o0_valid), .o0_ready(x_o0_ready), .o0(x_o0),
    .o1_valid(x_o1_valid), .o1_ready(x_o1_ready), .o1(x_o1),
    .level0(x_level0), .level1(x_level1), .af0(x_af0), .af1(x_af1)
  );

  xrange_xfifo #(
    .HI(3), .LO(-4), .DEPTH(4), .AF_LEVEL(3), .CROSS("FALSE"), .IDLE_VAL(8'hA5)
  ) dut_s (
    .clk(clk), .rst(rst),
    .i0_valid(s_i0_valid), .i0_ready(s_i0_ready), .i0(s_i0),
    .i1_valid(s_i1_valid), .i1_ready(s_i1_ready), .i1(s_i1),
    .o0_valid(s_o0_valid), .o0_ready(s_o0_ready), .o0(s_o0),
    .o1_valid(s_o1_valid), .o1_ready(s_o1_ready), .o1(s_o1),
    .level0(s_level0), .level1(s_level1), .af0(s_af0), .af1(s_af1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=<no entry expected>", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: head is compared every cycle it is presented, popped on a transfer
  always @(negedge clk) if (!rst && m_o0_valid) begin
    if (q_m_o0.size() == 0) flag("m_o0_unexpected", m_o0);
    else begin
      chk("m_o0_data", m_o0, q_m_o0[0]);
      if (m_o0_ready) void'(q_m_o0.pop_front());
    end
  end
  always @(negedge clk) if (!rst && m_o1_valid) begin
    if (q_m_o1.size() == 0) flag("m_o1_unexpected", m_o1);
    else begin
      chk("m_o1_data", m_o1, q_m_o1[0]);
      if (m_o1_ready) void'(q_m_o1.pop_front());
    end
  end
  always @(negedge clk) if (!rst && x_o0_valid) begin
    if (q_x_o0.size() == 0) flag("x_o0_unexpected", x_o0);
    else begin
      chk("x_o0_data", x_o0, q_x_o0[0]);
      if (x_o0_ready) void'(q_x_o0.pop_front());
    end
  end
  always @(negedge clk) if (!rst && x_o1_valid) begin
    if (q_x_o1.size() == 0) flag("x_o1_unexpected", x_o1);
    else begin
      chk("x_o1_data", x_o1, q_x_o1[0]);
      if (x_o1_ready) void'(q_x_o1.pop_front());
    end
  end
  always @(negedge clk) if (!rst && s_o0_valid) begin
    if (q_s_o0.size() == 0) flag("s_o0_unexpected", s_o0);
    else begin
      chk("s_o0_data", s_o0, q_s_o0[0]);
      if (s_o0_ready) void'(q_s_o0.pop_front());
    end
  end
  always @(negedge clk) if (!rst && s_o1_valid) begin
    if (q_s_o1.size() == 0) flag("s_o1_unexpected", s_o1);
    else begin
      chk("s_o1_data", s_o1, q_s_o1[0]);
      if (s_o1_ready) void'(q_s_o1.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_i0_valid = 0; m_i1_valid = 0; m_i0 = '0; m_i1 = '0; m_o0_ready = 0; m_o1_ready = 0;
    x_i0_valid = 0; x_i1_valid = 0; x_i0 = '0; x_i1 = '0; x_o0_ready = 1; x_o1_ready = 1;
    s_i0_valid = 0; s_i1_valid = 0; s_i0 = '0; s_i1 = '0; s_o0_ready = 0; s_o1_ready = 0;

    // reset state
    tick(); tick();
    chk("rst_i0_ready", m_i0_ready, 0);
    chk("rst_i1_ready", m_i1_ready, 0);
    chk("rst_level0", m_level0, 0);
    chk("rst_o0_valid", m_o0_valid, 0);
    chk("rst_o1_idle", m_o1, 5'h00);
    chk("rst_af0", m_af0, 0);
    rst = 0;
    tick();
    chk("rst_rel_i0_ready", m_i0_ready, 1);

    // test 1: positional crossing i1 -> o0
    m_i1 = 5'b00011; m_i1_valid = 1; q_m_o0.push_back(5'b00011);
    tick();
    m_i1_valid = 0;
    chk("t1_o0_valid", m_o0_valid, 1);
    chk("t1_o0_data", m_o0, 5'b00011);
    chk("t1_o0_bit_m1", m_o0[-1], 1);
    chk("t1_level1", m_level1, 1);
    m_o0_ready = 1;
    tick();
    m_o0_ready = 0;
    chk("t1_level1_pop", m_level1, 0);
    chk("t1_o0_valid_pop", m_o0_valid, 0);
    chk("t1_o0_idle", m_o0, 5'h00);

    // test 2: index mapping
    x_i1 = 5'b00011; x_i1_valid = 1; q_x_o0.push_back(5'b11000);
    tick();
    x_i1_valid = 0;
    chk("t2_o0_data", x_o0, 5'b11000);
    chk("t2_o0_bit2", x_o0[2], 1);
    x_i0 = 5'b10000; x_i0_valid = 1; q_x_o1.push_back(5'b00001);
    tick();
    chk("t2_o1_data", x_o1, 5'b00001);
    chk("t2_o1_bit2", x_o1[2], 1);
    x_i0 = 5'b10110; q_x_o1.push_back(5'b01101);
    tick();
    x_i0_valid = 0;
    chk("t2_o1_data2", x_o1, 5'b01101);
    tick(); tick();
    chk("t2_sb_empty", q_x_o0.size() + q_x_o1.size(), 0);

    // test 3: fill channel 0 to full, then drain under backpressure
    m_o1_ready = 0;
    for (int i = 0; i < 16; i++) begin
      m_i0 = 5'(i * 7 + 3);
      chk("t3_ready", m_i0_ready, 1);
      m_i0_valid = 1;
      q_m_o1.push_back(m_i0);
      tick();
      if (i == 8) chk("t3_af_9", m_af0, 0);
      if (i == 9) chk("t3_af_10", m_af0, 1);
    end
    m_i0 = 5'h1F;
    chk("t3_full_ready", m_i0_ready, 0);
    chk("t3_full_level", m_level0, 16);
    tick();
    m_i0_valid = 0;
    chk("t3_ignored_level", m_level0, 16);
    m_o1_ready = 1;
    tick();
    chk("t3_ready_after_pop", m_i0_ready, 1);
    chk("t3_level_after_pop", m_level0, 15);
    for (int c = 0; c < 64 && m_level0 != 0; c++) begin
      m_o1_ready = c[0];
      tick();
    end
    m_o1_ready = 0;
    chk("t3_drained", m_level0, 0);
    chk("t3_sb_empty", q_m_o1.size(), 0);
    chk("t3_af_clear", m_af0, 0);

    // test 4: level 8 with simultaneous push and pop, pointers wrap
    m_o0_ready = 0;
    for (int i = 0; i < 8; i++) begin
      m_i1 = 5'(i * 3 + 1); m_i1_valid = 1; q_m_o0.push_back(m_i1);
      tick();
    end
    chk("t4_level8", m_level1, 8);
    m_o0_ready = 1;
    for (int i = 0; i < 20; i++) begin
      m_i1 = 5'(i * 5 + 2); q_m_o0.push_back(m_i1);
      tick();
      chk("t4_level_steady", m_level1, 8);
    end
    m_i1_valid = 0;
    for (int c = 0; c < 32 && m_level1 != 0; c++) tick();
    m_o0_ready = 0;
    chk("t4_drained", m_level1, 0);
    chk("t4_sb_empty", q_m_o0.size(), 0);

    // test 5: reset in the middle of traffic
    for (int i = 0; i < 5; i++) begin
      m_i0 = 5'(i + 20); m_i0_valid = 1; q_m_o1.push_back(m_i0);
      tick();
    end
    chk("t5_level5", m_level0, 5);
    m_i0 = 5'h0A; m_o1_ready = 1; rst = 1;
    tick();
    chk("t5_level0", m_level0, 0);
    chk("t5_o1_valid", m_o1_valid, 0);
    chk("t5_o1_idle", m_o1, 5'h00);
    chk("t5_i0_ready", m_i0_ready, 0);
    chk("t5_af0", m_af0, 0);
    q_m_o1.delete();
    rst = 0; m_i0_valid = 0; m_o1_ready = 0;
    tick();
    chk("t5_ready_back", m_i0_ready, 1);
    m_i0 = 5'h15; m_i0_valid = 1; q_m_o1.push_back(5'h15);
    tick();
    m_i0_valid = 0;
    chk("t5_new_valid", m_o1_valid, 1);
    chk("t5_new_data", m_o1, 5'h15);
    m_o1_ready = 1;
    tick();
    m_o1_ready = 0;
    chk("t5_new_popped", m_level0, 0);

    // test 6: narrow uncrossed instance, bit-identical and depth 4
    chk("t6_o0_idle", s_o0, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      s_i0 = 8'(i * 37 + 11); s_i0_valid = 1; q_s_o0.push_back(s_i0);
      tick();
    end
    s_i0_valid = 0;
    chk("t6_full_ready", s_i0_ready, 0);
    chk("t6_level4", s_level0, 4);
    chk("t6_af", s_af0, 1);
    chk("t6_head", s_o0, 8'h0B);
    s_i1 = 8'h3C; s_i1_valid = 1; q_s_o1.push_back(8'h3C);
    tick();
    s_i1_valid = 0;
    chk("t6_o1_data", s_o1, 8'h3C);
    s_o0_ready = 1; s_o1_ready = 1;
    for (int c = 0; c < 16 && (s_level0 != 0 || s_level1 != 0); c++) tick();
    chk("t6_drained", s_level0, 0);
    chk("t6_o0_idle_end", s_o0, 8'hA5);

    // final scoreboard state
    tick(); tick();
    chk("end_sb_m", q_m_o0.size() + q_m_o1.size(), 0);
    chk("end_sb_x", q_x_o0.size() + q_x_o1.size(), 0);
    chk("end_sb_s", q_s_o0.size() + q_s_o1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xrange_xfifo.md
Name: xrange_xfifo

Overview:
Two-channel cross-coupled FIFO between mixed-orientation buses. A descending-range input `[HI:LO]` and an ascending-range input `[LO:HI]` each buffer into their own FIFO. The outputs are crossed, so i0 drains to o1 and i1 drains to o0. This is the generalised, clocked successor of our mixed-range bus fixture: ranges, depth, crossing and bit-mapping mode are all parameters. It also serves as a netlist-writer regression block for negative indices, string parameters and hex parameters.

Parameters:
- HI, 2, upper index of both buses; HI >= LO, negative values allowed.
- LO, -2, lower index; W = HI-LO+1 (default 5).
- DEPTH, 16, entries per channel; power of two, >= 2.
- AF_LEVEL, 10, almost-full threshold; 1..DEPTH.
- CROSS, "TRUE", "TRUE": i0->o1, i1->o0. "FALSE": i0->o0, i1->o1.
- MAP, "POSITIONAL", "POSITIONAL": MSB-first position preserved. "INDEX": numeric index preserved.
- IDLE_VAL, 5'h0, W-bit value driven on a data output while its channel is empty or in reset.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- i0_valid, input, 1, channel-0 write request.
- i0_ready, output, 1, channel-0 can accept.
- i0, input, [HI:LO], channel-0 write data.
- i1_valid, input, 1, channel-1 write request.
- i1_ready, output, 1, channel-1 can accept.
- i1, input, [LO:HI], channel-1 write data.
- o0_valid, output, 1, o0 holds a valid head entry.
- o0_ready, input, 1, sink consumes o0.
- o0, output, [HI:LO], head data of the channel routed to o0.
- o1_valid, output, 1, o1 holds a valid head entry.
- o1_ready, input, 1, sink consumes o1.
- o1, output, [LO:HI], head data of the channel routed to o1.
- level0, output, $clog2(DEPTH)+1, occupancy of the FIFO fed by i0.
- level1, output, $clog2(DEPTH)+1, occupancy of the FIFO fed by i1.
- af0, output, 1, level0 >= AF_LEVEL.
- af1, output, 1, level1 >= AF_LEVEL.

Behaviour:
- Channel c is the FIFO fed by i<c>. Both channels are identical and fully independent.
- **Push:** i<c>_valid & i<c>_ready at a rising edge.
- **Pop:** valid & ready on the output port the channel is routed to.
- **Ready:** i<c>_ready = !full & !rst, combinational from registered state only (no path from valid).
- **Output valid/data:** o*_valid = (level != 0), registered.
  - Data is the head entry, show-ahead.
  - Data is IDLE_VAL when level = 0.
  - Data is held stable while valid & !ready.
- **Latency:** a word pushed at edge N appears on the output after edge N. There is no same-cycle combinational bypass.
- **Bit mapping, applied at write time** (storage is kept in destination orientation):
  - POSITIONAL: dest[HI-j] <-> src[LO+j] for ascending-to-descending; same rule mirrored the other way. This matches the plain Verilog assignment o = i.
  - INDEX: dest[k] = src[k] for all k in LO..HI.
  - With CROSS="FALSE", source and destination orientations match, so MAP has no effect.
- **Level rules:**
  - push only: level+1.
  - pop only: level-1.
  - push & pop in the same cycle: level unchanged, pointers both advance.
- **Full** (level = DEPTH): ready=0, and an asserted valid is ignored without being stored or counted. A pop while full frees one slot; ready rises after that edge.
- **Empty:** a pop cannot occur because valid=0. Pushing into an empty FIFO with ready held high pops that word on the following edge.
- **Wrap-around:** read/write pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. Full/empty are derived from level, not from pointer equality.
- **af<c>:** registered, updated on the same edge as level.
- **Reset (rst=1 at an edge), including mid-transfer:**
  - Pointers = 0, level = 0, af = 0, o*_valid = 0, o* = IDLE_VAL.
  - i*_ready = 0 while rst is high.
  - Any in-flight push or pop in that cycle is discarded and storage contents are dropped.
  - After rst deasserts, i*_ready = 1 on the following cycle.
- **Elaboration checks:** error if HI < LO, DEPTH is not a power of two, AF_LEVEL is outside 1..DEPTH, or CROSS/MAP hold an unknown string.

Test Plan:
1. Defaults, POSITIONAL. Push i1 = 5'b00011 (i1[1]=i1[2]=1). Next cycle: o0_valid=1, o0=5'b00011 (o0[-1]=o0[-2]=1), level1=1; pop with o0_ready -> level1=0, o0=IDLE_VAL.
2. MAP="INDEX". Same push -> o0=5'b11000 (o0[2]=o0[1]=1). Push i0=5'b10000 -> o1[2]=1, all other o1 bits 0.
3. Fill channel 0 with 16 words, o1_ready=0:
   - af0 rises after the 10th push; i0_ready=0 after the 16th.
   - A 17th valid is ignored, level0 stays 16.
   - Drain: order preserved, o1 held stable under backpressure.
4. Level 8: simultaneous push & pop for 20 cycles -> level stays 8, pointers wrap, data order intact.
5. Reset asserted with level0=5 and a push/pop active -> after that edge: level0=0, o1_valid=0, o1=IDLE_VAL, i0_ready=0. After rst deasserts: i0_ready=1 next cycle, and a new push appears normally.
6. HI=3, LO=-4, DEPTH=4, CROSS="FALSE": i0 -> o0 bit-identical, 8-bit paths, full after 4 pushes.
